hall_call_dispatcher: RTL

Schedules landing (hall) calls across a bank of lift cars. Each car runs its own lift controller with its own request queue. Hall up/down buttons are latched here, and each call is assigned to exactly one car by a distance/direction cost. The block then issues a single-cycle up/down request pulse into that car's request handler. It sits above the per-car controller instances and drives the hall-lamp outputs.

---
 rtl/hall_call_dispatcher.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher: latches landing calls, assigns each one to the cheapest
// available car by distance/direction cost, and emits a one-cycle request pulse
// into that car's queue. One assignment is in flight at a time.
module hall_call_dispatcher #(
  parameter int  N_FLOORS = 8,
  parameter int  N_CARS   = 2,
  localparam int FW       = $clog2(N_FLOORS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_FLOORS-1:0]        hall_up_rqst,
  input  logic [N_FLOORS-1:0]        hall_dn_rqst,
  input  logic [N_CARS*FW-1:0]       car_pos,
  input  logic [N_CARS-1:0]          car_motion,
  input  logic [N_CARS-1:0]          car_direction,
  input  logic [N_CARS-1:0]          car_avail,
  input  logic [N_CARS*N_FLOORS-1:0] car_up_served,
  input  logic [N_CARS*N_FLOORS-1:0] car_dn_served,
  output logic [N_CARS*N_FLOORS-1:0] car_up_rqst,
  output logic [N_CARS*N_FLOORS-1:0] car_dn_rqst,
  output logic [N_FLOORS-1:0]        hall_up_lamp,
  output logic [N_FLOORS-1:0]        hall_dn_lamp,
  output logic                       busy
);
  localparam int NI = 2 * N_FLOORS;
  localparam int PW = $clog2(NI);
  localparam int CW = (N_CARS > 1) ? $clog2(N_CARS) : 1;
  localparam int KW = FW + 2;

  typedef enum logic [1:0] {IDLE, SCAN, EVAL, ISSUE} state_t;
  state_t state, state_nxt;

  logic [N_FLOORS-1:0] up_pend, dn_pend, up_asgn, dn_asgn;
  logic [NI-1:0]       pend_vec;
  logic [PW-1:0]       ptr, sel, call, ptr_nxt;
  logic                any_pend, call_up;
  logic [FW-1:0]       tgt, pos;
  logic [CW-1:0]       cnt, best_car, nxt_car;
  logic [KW-1:0]       best_cost, cost;
  logic                best_valid, nxt_valid, take, last, mv, dir;
  logic                do_latch, do_eval, do_issue, do_fail, fire;

  assign pend_vec = {dn_pend, up_pend};
  assign any_pend = |pend_vec;
  assign call_up  = int'(call) < N_FLOORS;
  assign tgt      = call_up ? FW'(call) : FW'(int'(call) - N_FLOORS);
  assign ptr_nxt  = (int'(call) == NI - 1) ? '0 : call + PW'(1);

  // Round-robin pick: first pending index at or after the pointer, with wrap
  always_comb begin
    int idx;
    idx = 0;
    sel = '0;
    for (int i = NI - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NI) idx -= NI;
      if (pend_vec[idx]) sel = PW'(idx);
    end
  end

  assign pos  = car_pos[int'(cnt)*FW +: FW];
  assign mv   = car_motion[cnt];
  assign dir  = car_direction[cnt];
  assign last = (cnt == CW'(N_CARS - 1));

  // Cost of the car under evaluation: distance, heavy penalty when the target
  // is behind a moving car, +1 tie-break for a parked car facing the wrong way
  always_comb begin
    cost = (pos > tgt) ? KW'(pos - tgt) : KW'(tgt - pos);
    if (mv && ((dir && tgt < pos) || (!dir && tgt > pos))) cost = cost + KW'(N_FLOORS);
    if (!mv && pos == tgt && call_up != dir) cost = cost + KW'(1);
  end

  assign take      = car_avail[cnt] && (cost < best_cost);
  assign nxt_valid = best_valid || take;
  assign nxt_car   = take ? cnt : best_car;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pend) state_nxt = SCAN;
      SCAN:    state_nxt = EVAL;
      EVAL:    if (last) state_nxt = nxt_valid ? ISSUE : IDLE;
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode: busy flag and datapath strobes
  always_comb begin
    busy     = (state != IDLE);
    do_latch = (state == SCAN);
    do_eval  = (state == EVAL);
    do_issue = (state == ISSUE);
    fire     = do_eval && last && nxt_valid;
    do_fail  = do_eval && last && !nxt_valid;
  end

  // Selection datapath: latched call, running best, car counter, RR pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      call       <= '0;
      ptr        <= '0;
      cnt        <= '0;
      best_car   <= '0;
      best_cost  <= '1;
      best_valid <= 1'b0;
    end else begin
      if (do_latch) begin
        call       <= sel;
        cnt        <= '0;
        best_cost  <= '1;
        best_valid <= 1'b0;
      end
      if (do_eval) begin
        cnt        <= cnt + CW'(1);
        best_valid <= nxt_valid;
        best_car   <= nxt_car;
        if (take) best_cost <= cost;
      end
      if (do_fail || do_issue) ptr <= ptr_nxt;
    end
  end

  // Assignment pulses, registered so they coincide with the ISSUE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      car_up_rqst <= '0;
      car_dn_rqst <= '0;
    end else begin
      car_up_rqst <= '0;
      car_dn_rqst <= '0;
      if (fire) begin
        if (call_up) car_up_rqst[int'(nxt_car)*N_FLOORS + int'(tgt)] <= 1'b1;
        else         car_dn_rqst[int'(nxt_car)*N_FLOORS + int'(tgt)] <= 1'b1;
      end
    end
  end

  for (genvar f = 0; f < N_FLOORS; f++) begin : g_call
    logic          up_p, up_a, dn_p, dn_a;
    logic [CW-1:0] up_o, dn_o;
    logic          up_clr, dn_clr, up_iss, dn_iss;

    assign up_clr = up_a && car_up_served[int'(up_o)*N_FLOORS + f];
    assign dn_clr = dn_a && car_dn_served[int'(dn_o)*N_FLOORS + f];
    assign up_iss = do_issue && (int'(call) == f);
    assign dn_iss = do_issue && (int'(call) == N_FLOORS + f);

    // Per-call FREE/PENDING/ASSIGNED tracking; a new press beats an owner clear
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        up_p <= 1'b0; up_a <= 1'b0; up_o <= '0;
        dn_p <= 1'b0; dn_a <= 1'b0; dn_o <= '0;
      end else begin
        if (up_iss) begin
          up_p <= 1'b0; up_a <= 1'b1; up_o <= best_car;
        end else if (up_clr) begin
          up_a <= 1'b0; up_p <= hall_up_rqst[f];
        end else if (!up_p && !up_a && hall_up_rqst[f]) begin
          up_p <= 1'b1;
        end
        if (dn_iss) begin
          dn_p <= 1'b0; dn_a <= 1'b1; dn_o <= best_car;
        end else if (dn_clr) begin
          dn_a <= 1'b0; dn_p <= hall_dn_rqst[f];
        end else if (!dn_p && !dn_a && hall_dn_rqst[f]) begin
          dn_p <= 1'b1;
        end
      end
    end

    assign up_pend[f] = up_p;
    assign up_asgn[f] = up_a;
    assign dn_pend[f] = dn_p;
    assign dn_asgn[f] = dn_a;
  end

  assign hall_up_lamp = up_pend | up_asgn;
  assign hall_dn_lamp = dn_pend | dn_asgn;

endmodule
